synth_buffer_playback_ctrl: RTL and testbench

- Sequences playback of the PS-filled SynthBuffer BRAM into the I2S transmit path.
- Treats the BRAM as a ping-pong buffer of two halves, owned alternately by the PS (filling) and this block (draining).
- Fetches 32-bit sample words over a BRAM port and hands them to the I2S serializer over a valid/ready handshake.
- Reports half-buffer completion and underruns back to the PS-side register block.

---
 rtl/synth_buffer_playback_ctrl.sv | 103 ++++++++++
 tb/tb_synth_buffer_playback_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/synth_buffer_playback_ctrl.sv
// synth_buffer_playback_ctrl: drains a ping-pong BRAM buffer into a valid/ready sample stream
module synth_buffer_playback_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       buf_fill_set,
  output logic [31:0]      BRAM_addr,
  output logic             BRAM_clk,
  output logic [31:0]      BRAM_din,
  input  logic [31:0]      BRAM_dout,
  output logic             BRAM_en,
  output logic             BRAM_rst,
  output logic [3:0]       BRAM_we,
  output logic [31:0]      sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             half_done,
  output logic             half_done_idx,
  output logic [1:0]       buf_filled,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic             fill_err
);
  localparam int HALF = DEPTH_WORDS / 2;
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, UNDERRUN} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] word_index, index_nxt;
  logic cur_half, half_nxt, accept, last, own, clr;
  logic [1:0] own_mask, clr_mask, fill_nxt;
  assign accept = sample_valid && sample_ready;
  assign last = word_index == (cur_half ? IW'(DEPTH_WORDS - 1) : IW'(HALF - 1));
  assign own = state inside {FETCH, WAIT, HOLD};
  assign clr = state == HOLD && accept && last;
  assign own_mask = {own && cur_half, own && !cur_half};
  assign clr_mask = {clr && cur_half, clr && !cur_half};
  assign fill_nxt = (buf_filled | (buf_fill_set & ~own_mask)) & ~clr_mask;
  assign BRAM_clk = clk;
  assign BRAM_rst = rst;
  assign BRAM_din = '0;
  assign BRAM_we = '0;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    index_nxt = word_index;
    half_nxt = cur_half;
    case (state)
      IDLE: state_nxt = enable && buf_filled[cur_half] ? FETCH : IDLE;
      FETCH: state_nxt = WAIT;
      WAIT: state_nxt = HOLD;
      HOLD: if (accept) begin
        index_nxt = last ? (cur_half ? '0 : IW'(HALF)) : word_index + 1'b1;
        half_nxt = cur_half ^ last;
        state_nxt = fill_nxt[half_nxt] ? FETCH : UNDERRUN;
      end
      UNDERRUN: if (accept) state_nxt = fill_nxt[cur_half] ? FETCH : UNDERRUN;
      default: state_nxt = IDLE;
    endcase
    if ((state == HOLD || state == UNDERRUN) && accept && !enable) begin
      state_nxt = IDLE;
      index_nxt = '0;
      half_nxt = 1'b0;
    end
  end
  always_comb begin
    BRAM_en = state == FETCH;
    BRAM_addr = BRAM_en ? BASE_ADDR + (32'(word_index) << 2) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_index <= '0;
      cur_half <= 1'b0;
      buf_filled <= '0;
      fill_err <= 1'b0;
      half_done <= 1'b0;
      half_done_idx <= 1'b0;
      underrun_cnt <= '0;
      sample_valid <= 1'b0;
      sample_data <= '0;
    end else begin
      word_index <= index_nxt;
      cur_half <= half_nxt;
      buf_filled <= fill_nxt;
      fill_err <= fill_err | (|(buf_fill_set & own_mask));
      half_done <= clr;
      if (clr) half_done_idx <= cur_half;
      if (state == UNDERRUN && accept && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
      if (state == WAIT) begin
        sample_valid <= 1'b1;
        sample_data <= BRAM_dout;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end else if (state == UNDERRUN) begin
        sample_valid <= 1'b1;
        sample_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_synth_buffer_playback_ctrl.sv
// tb_synth_buffer_playback_ctrl: randomized and directed checks against a sample-stream model
module tb_synth_buffer_playback_ctrl;
  logic clk = 0, rst = 1, enable = 0, sample_ready = 0;
  logic [1:0] buf_fill_set = 0;
  logic [31:0] BRAM_addr, BRAM_din, sample_data;
  logic [31:0] bram_dout = 0;
  logic BRAM_clk, BRAM_en, BRAM_rst, sample_valid, half_done, half_done_idx, fill_err;
  logic [3:0] BRAM_we;
  logic [1:0] buf_filled;
  logic [2:0] underrun_cnt;
  logic [31:0] mem [8];
  int n_chk = 0, n_fail = 0;
  int p, cnt, n_data, n_zero, n_hd;
  logic mode, hd, hdi, err;
  logic [1:0] mf;
  synth_buffer_playback_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .buf_fill_set(buf_fill_set),
    .BRAM_addr(BRAM_addr), .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din), .BRAM_dout(bram_dout),
    .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_we(BRAM_we),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .half_done(half_done), .half_done_idx(half_done_idx), .buf_filled(buf_filled),
    .underrun_cnt(underrun_cnt), .fill_err(fill_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (BRAM_en) bram_dout <= mem[BRAM_addr[4:2]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic en, input logic [1:0] fs, input logic rdy);
    logic acc;
    rst = r;
    enable = en;
    buf_fill_set = fs;
    sample_ready = rdy;
    acc = !r && sample_valid && rdy;
    if (!r && BRAM_en) chk("fetch_addr", BRAM_addr, 32'(p * 4));
    if (acc) chk("sample_data", sample_data, mode ? mem[p] : 32'h0);
    @(posedge clk);
    hd = 0;
    if (r) begin
      p = 0; mode = 1; mf = 0; cnt = 0; hdi = 0; err = 0;
      n_data = 0; n_zero = 0; n_hd = 0;
    end else begin
      mf = mf | fs;
      if (acc) begin
        if (mode) begin
          n_data++;
          if (p % 4 == 3) begin
            mf[p / 4] = 1'b0;
            hd = 1;
            hdi = 1'(p / 4);
            n_hd++;
          end
          p = (p + 1) % 8;
        end else begin
          n_zero++;
          cnt = cnt == 7 ? 7 : cnt + 1;
        end
        if (!en) p = 0;
        mode = en ? mf[p / 4] : 1'b1;
      end
    end
    @(negedge clk);
    buf_fill_set = 0;
    chk("half_done", half_done, hd);
    if (hd) chk("half_done_idx", half_done_idx, hdi);
    chk("buf_filled", buf_filled, mf);
    chk("underrun_cnt", underrun_cnt, cnt);
    chk("fill_err", fill_err, err);
  endtask
  initial begin
    int t;
    logic [31:0] d;
    logic seen;
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_en", BRAM_en, 0);
    chk("rst_addr", BRAM_addr, 0);
    chk("rst_we", BRAM_we, 0);
    chk("rst_din", BRAM_din, 0);
    chk("rst_hd_idx", half_done_idx, 0);
    step(0, 1, 2'b01, 1);
    for (int i = 0; i < 100 && !(n_zero == 2 && sample_valid); i++) step(0, 1, 0, 1);
    chk("t1_data", n_data, 4);
    chk("t1_hd", n_hd, 1);
    step(0, 1, 2'b10, 1);
    chk("t2_cnt3", underrun_cnt, 3);
    for (int i = 0; i < 100 && n_data < 8; i++) step(0, 1, 0, 1);
    chk("t2_drain", n_data, 8);
    chk("t2_cnt_hold", underrun_cnt, 3);
    chk("t2_hd", n_hd, 2);
    step(0, 1, 2'b01, 1);
    for (int i = 0; i < 100 && n_data < 9; i++) step(0, 1, 0, 1);
    chk("t2_wrap", n_data, 9);
    step(1, 0, 0, 0);
    step(0, 1, 2'b01, 1);
    for (int i = 0; i < 100 && n_data < 2; i++) step(0, 1, 0, 1);
    chk("t3_wait", n_data, 2);
    err = 1;
    step(0, 1, 2'b01, 0);
    chk("t3_fill_err", fill_err, 1);
    for (int i = 0; i < 10 && !sample_valid; i++) step(0, 1, 0, 0);
    chk("t3_valid", sample_valid, 1);
    d = sample_data;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      chk("bp_valid", sample_valid, 1);
      chk("bp_data", sample_data, d);
      chk("bp_en", BRAM_en, 0);
    end
    step(0, 1, 0, 1);
    chk("bp_one", sample_valid, 0);
    chk("bp_count", n_data, 3);
    for (int i = 0; i < 10 && !sample_valid; i++) step(0, 1, 0, 0);
    step(0, 0, 2'b10, 0);
    chk("t4_hold", sample_valid, 1);
    step(0, 0, 0, 1);
    chk("t4_accept", n_data, 4);
    step(0, 0, 2'b01, 0);
    t = n_data + 1;
    seen = 0;
    for (int i = 0; i < 100 && n_data < t; i++) begin
      if (BRAM_en && !seen) begin
        seen = 1;
        chk("t4_restart_addr", BRAM_addr, 0);
      end
      step(0, 1, 0, 1);
    end
    chk("t4_restart", n_data, t);
    for (int i = 0; i < 20 && !BRAM_en; i++) step(0, 1, 0, 1);
    chk("t5_fetch", BRAM_en, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("t5_valid", sample_valid, 0);
    chk("t5_en", BRAM_en, 0);
    chk("t5_filled", buf_filled, 0);
    chk("t5_cnt", underrun_cnt, 0);
    chk("t5_err", fill_err, 0);
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] fs;
      for (int h = 0; h < 2; h++) fs[h] = !mf[h] && $urandom_range(0, 7) == 0;
      step(0, $urandom_range(0, 9) != 0, fs, $urandom_range(0, 2) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
